npu_layer_seq: RTL and testbench

- Autonomous inference sequencer for the NPU datapath. Replaces per-step host pokes with one start command.
- Drives the conv engine through conv1 and then CHAN conv2 channel passes, with partial-sum accumulation.
- Streams FC1 weight groups from a weight SRAM into the fcn PEs, waits for the FC2 logit and latches the result.
- Sits between the host register decoder and the conv / partial_sum / fcn instances.

---
 rtl/npu_layer_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_npu_layer_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_layer_seq.sv
// rtl/npu_layer_seq.sv - autonomous conv/fc inference sequencer for the NPU datapath
module npu_layer_seq #(
  parameter int CONV_PIX   = 132,
  parameter int CHAN       = 10,
  parameter int FC1_GROUPS = 330,
  parameter int WADDR_W    = 9,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [23:0]        result,
  output logic               conv_clear,
  output logic               conv_layer,
  output logic               conv_trigger,
  output logic               conv_save_done,
  input  logic               pixel_valid,
  output logic               psum_clear,
  output logic               wload_req,
  output logic [3:0]         wload_ch,
  input  logic               wload_ack,
  output logic               wmem_rd,
  output logic [WADDR_W-1:0] wmem_addr,
  input  logic [31:0]        wmem_rdata,
  output logic [3:0][7:0]    w_stream,
  output logic               fcn_start,
  output logic               fc1_next,
  input  logic               fc1_valid,
  input  logic               fcn_done,
  input  logic [23:0]        fcn_logit
);

  localparam int PIX_W = $clog2(CONV_PIX + 1);
  localparam int GRP_W = $clog2(FC1_GROUPS + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CONV1, S_C2_LOAD, S_C2_RUN, S_FC_START, S_FC_RD,
    S_FC_LOAD, S_FC_NEXT, S_FC_WAIT, S_FC2_WAIT, S_DONE, S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PIX_W-1:0]   r_pix;
  logic [3:0]         r_ch;
  logic [GRP_W-1:0]   r_grp;
  logic [WD_W-1:0]    r_wdog;
  logic [23:0]        r_result;
  logic [3:0][7:0]    r_w_stream;
  logic               w_pass_end;
  logic               w_wait_state;
  logic               w_timeout;
  logic               w_grp_last;

  // A pass ends on the pixel strobe that brings the count to CONV_PIX
  assign w_pass_end   = pixel_valid && (r_pix == PIX_W'(CONV_PIX - 1));
  assign w_wait_state = (r_state == S_CONV1) || (r_state == S_C2_LOAD) || (r_state == S_C2_RUN) ||
                        (r_state == S_FC_WAIT) || (r_state == S_FC2_WAIT);
  assign w_timeout    = w_wait_state && (r_wdog == WD_W'(TIMEOUT - 1));
  assign w_grp_last   = (r_grp == GRP_W'(FC1_GROUPS - 1));
  assign result       = r_result;
  assign w_stream     = r_w_stream;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and Mealy outputs; abort overrides everything and lands in IDLE
  always_comb begin
    w_next         = r_state;
    busy           = 1'b0;
    done           = 1'b0;
    err            = 1'b0;
    conv_clear     = 1'b0;
    conv_layer     = 1'b0;
    conv_trigger   = 1'b0;
    conv_save_done = 1'b0;
    psum_clear     = 1'b0;
    wload_req      = 1'b0;
    wload_ch       = 4'd0;
    wmem_rd        = 1'b0;
    wmem_addr      = '0;
    fcn_start      = 1'b0;
    fc1_next       = 1'b0;
    case (r_state)
      S_IDLE: begin
        conv_clear = 1'b1;
        if (start) begin
          conv_clear   = 1'b0;
          conv_trigger = 1'b1;
          w_next       = S_CONV1;
        end
      end
      S_CONV1: begin
        busy = 1'b1;
        if (w_pass_end) begin
          conv_save_done = 1'b1;
          psum_clear     = 1'b1;
          conv_clear     = 1'b1;
          w_next         = S_C2_LOAD;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_C2_LOAD: begin
        busy     = 1'b1;
        wload_ch = r_ch;
        if (wload_ack) begin
          conv_layer   = 1'b1;
          conv_trigger = 1'b1;
          w_next       = S_C2_RUN;
        end else begin
          wload_req = 1'b1;
          if (w_timeout) w_next = S_ERR;
        end
      end
      S_C2_RUN: begin
        busy       = 1'b1;
        conv_layer = 1'b1;
        if (w_pass_end) begin
          conv_save_done = 1'b1;
          conv_clear     = 1'b1;
          w_next         = (r_ch == 4'(CHAN - 1)) ? S_FC_START : S_C2_LOAD;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_FC_START: begin
        busy      = 1'b1;
        fcn_start = 1'b1;
        w_next    = S_FC_RD;
      end
      S_FC_RD: begin
        busy      = 1'b1;
        wmem_rd   = 1'b1;
        wmem_addr = WADDR_W'(r_grp);
        w_next    = S_FC_LOAD;
      end
      S_FC_LOAD: begin
        busy   = 1'b1;
        w_next = S_FC_NEXT;
      end
      S_FC_NEXT: begin
        busy     = 1'b1;
        fc1_next = 1'b1;
        w_next   = S_FC_WAIT;
      end
      S_FC_WAIT: begin
        busy = 1'b1;
        if (fc1_valid)      w_next = w_grp_last ? S_FC2_WAIT : S_FC_RD;
        else if (w_timeout) w_next = S_ERR;
      end
      S_FC2_WAIT: begin
        busy = 1'b1;
        if (fcn_done)       w_next = S_DONE;
        else if (w_timeout) w_next = S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          done         = 1'b0;
          conv_trigger = 1'b1;
          w_next       = S_CONV1;
        end
      end
      S_ERR: begin
        err        = 1'b1;
        conv_clear = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next         = S_IDLE;
      done           = 1'b0;
      err            = 1'b0;
      conv_clear     = 1'b1;
      conv_layer     = 1'b0;
      conv_trigger   = 1'b0;
      conv_save_done = 1'b0;
      psum_clear     = 1'b0;
      wload_req      = 1'b0;
      wload_ch       = 4'd0;
      wmem_rd        = 1'b0;
      wmem_addr      = '0;
      fcn_start      = 1'b0;
      fc1_next       = 1'b0;
    end
  end

  // Watchdog and pixel counters restart on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
      r_pix  <= '0;
    end else if (w_next != r_state) begin
      r_wdog <= '0;
      r_pix  <= '0;
    end else begin
      r_wdog <= w_wait_state ? r_wdog + WD_W'(1) : '0;
      if (pixel_valid && ((r_state == S_CONV1) || (r_state == S_C2_RUN)))
        r_pix <= r_pix + PIX_W'(1);
    end
  end

  // Channel and weight-group indices
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch  <= 4'd0;
      r_grp <= '0;
    end else begin
      if (r_state == S_CONV1 && w_next == S_C2_LOAD)       r_ch <= 4'd0;
      else if (r_state == S_C2_RUN && w_next == S_C2_LOAD) r_ch <= r_ch + 4'd1;
      if (r_state == S_FC_START)                           r_grp <= '0;
      else if (r_state == S_FC_WAIT && w_next == S_FC_RD)  r_grp <= r_grp + GRP_W'(1);
    end
  end

  // Weight word capture and logit latch; both hold across DONE and abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_stream <= '0;
      r_result   <= 24'd0;
    end else begin
      if (r_state == S_FC_LOAD && w_next == S_FC_NEXT)  r_w_stream <= wmem_rdata;
      if (r_state == S_FC2_WAIT && w_next == S_DONE)    r_result   <= fcn_logit;
    end
  end

endmodule

// File: tb/tb_npu_layer_seq.sv
// tb/tb_npu_layer_seq.sv - scoreboard bench for npu_layer_seq
module tb_npu_layer_seq;
  localparam int CONV_PIX   = 4;
  localparam int CHAN       = 2;
  localparam int FC1_GROUPS = 3;
  localparam int WADDR_W    = 9;
  localparam int TIMEOUT    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, pixel_valid = 1'b0, wload_ack = 1'b0;
  logic fc1_valid = 1'b0, fcn_done = 1'b0;
  logic [23:0] fcn_logit = 24'd0;
  logic [31:0] wmem_rdata = 32'd0;
  logic busy, done, err, conv_clear, conv_layer, conv_trigger, conv_save_done;
  logic psum_clear, wload_req, wmem_rd, fcn_start, fc1_next;
  logic [23:0] result;
  logic [3:0] wload_ch;
  logic [WADDR_W-1:0] wmem_addr;
  logic [3:0][7:0] w_stream;

  npu_layer_seq #(.CONV_PIX(CONV_PIX), .CHAN(CHAN), .FC1_GROUPS(FC1_GROUPS),
                  .WADDR_W(WADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .err(err), .result(result), .conv_clear(conv_clear), .conv_layer(conv_layer),
    .conv_trigger(conv_trigger), .conv_save_done(conv_save_done),
    .pixel_valid(pixel_valid), .psum_clear(psum_clear), .wload_req(wload_req),
    .wload_ch(wload_ch), .wload_ack(wload_ack), .wmem_rd(wmem_rd),
    .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata), .w_stream(w_stream),
    .fcn_start(fcn_start), .fc1_next(fc1_next), .fc1_valid(fc1_valid),
    .fcn_done(fcn_done), .fcn_logit(fcn_logit)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:2];
  initial begin
    mem[0] = 32'h04030201;
    mem[1] = 32'h08070605;
    mem[2] = 32'h0C0B0A09;
  end

  // Weight SRAM model with one-cycle read latency
  always @(posedge clk) begin
    if (wmem_rd) wmem_rdata <= (wmem_addr < 3) ? mem[wmem_addr[1:0]] : 32'hDEADBEEF;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_trig   = 0;
  int n_save   = 0;
  bit exp_trig[$];
  bit exp_psum[$];
  logic [3:0]  exp_ch[$];
  logic [31:0] exp_w[$];
  logic [23:0] exp_res[$];
  bit tl;
  logic prev_done = 1'b0, prev_fcn_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (rst) begin
      prev_done     = 1'b0;
      prev_fcn_done = 1'b0;
    end else begin
      if (conv_trigger) begin
        n_trig++;
        if (exp_trig.size() == 0) chk("unexpected_trigger", 1, 0);
        else begin
          tl = exp_trig.pop_front();
          chk("trigger_layer", conv_layer, tl);
          if (tl) begin
            if (exp_ch.size() == 0) chk("unexpected_ch", 1, 0);
            else chk("wload_ch", wload_ch, exp_ch.pop_front());
          end
        end
      end
      if (conv_save_done) begin
        n_save++;
        if (exp_psum.size() == 0) chk("unexpected_save_done", 1, 0);
        else chk("psum_clear_at_save", psum_clear, exp_psum.pop_front());
        chk("conv_clear_at_save", conv_clear, 1);
      end else if (psum_clear) begin
        chk("stray_psum_clear", 1, 0);
      end
      if (fc1_next) begin
        if (exp_w.size() == 0) chk("unexpected_fc1_next", 1, 0);
        else chk("w_stream", w_stream, exp_w.pop_front());
      end
      if (done && !prev_done) begin
        chk("done_latency", prev_fcn_done, 1);
        if (exp_res.size() == 0) chk("unexpected_done", 1, 0);
        else chk("result", result, exp_res.pop_front());
      end
      prev_done     = done;
      prev_fcn_done = fcn_done;
    end
  end

  task automatic pixels(input int n);
    pixel_valid = 1'b1;
    repeat (n) step();
    pixel_valid = 1'b0;
  endtask

  task automatic do_start(input bit from_done);
    exp_trig.push_back(1'b0);
    start = 1'b1;
    #1;
    if (from_done) begin
      chk("done_drop_on_start", done, 0);
      chk("trigger_on_restart", conv_trigger, 1);
    end
    step();
    start = 1'b0;
  endtask

  task automatic conv_phase(input int conv1_pix);
    int save0;
    save0 = n_save;
    exp_psum.push_back(1'b1);
    pixels(conv1_pix);
    chk("conv1_save_count", n_save, save0 + 1);
    for (int c = 0; c < CHAN; c++) begin
      repeat (2) step();
      chk("wload_req_level", wload_req, 1);
      chk("wload_ch_level", wload_ch, c);
      exp_ch.push_back(4'(c));
      exp_trig.push_back(1'b1);
      wload_ack = 1'b1;
      step();
      wload_ack = 1'b0;
      exp_psum.push_back(1'b0);
      if (c == 0 && conv1_pix > CONV_PIX) begin
        pixels(CONV_PIX - 1);
        chk("no_early_save", n_save, save0 + 1);
        pixels(1);
      end else begin
        pixels(CONV_PIX);
      end
      chk("c2_save_count", n_save, save0 + 2 + c);
    end
  endtask

  task automatic wait_fc1_next();
    int i;
    i = 0;
    while (!fc1_next && i < 40) begin
      step();
      i++;
    end
    chk("fc1_next_seen", fc1_next, 1);
  endtask

  task automatic fc_phase(input bit stress, input logic [23:0] logit, input logic [23:0] old_res);
    for (int g = 0; g < FC1_GROUPS; g++) begin
      exp_w.push_back(mem[g]);
      wait_fc1_next();
      if (stress && g == 0) fc1_valid = 1'b1;
      step();
      fc1_valid = 1'b0;
      if (stress && g == 0) begin
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start_in_fc_wait", busy, 1);
        chk("still_waiting_fc1", fc1_next | wmem_rd, 0);
      end
      fc1_valid = 1'b1;
      step();
      fc1_valid = 1'b0;
    end
    repeat (2) step();
    chk("result_held_before_fcn_done", result, old_res);
    chk("not_done_before_fcn_done", done, 0);
    exp_res.push_back(logit);
    fcn_logit = logit;
    fcn_done  = 1'b1;
    step();
    fcn_done  = 1'b0;
    chk("done_after_fcn_done", done, 1);
    chk("busy_in_done", busy, 0);
  endtask

  task automatic full_run(input int conv1_pix, input bit stress, input bit from_done,
                          input logic [23:0] logit, input logic [23:0] old_res);
    int trig0, save0;
    trig0 = n_trig;
    save0 = n_save;
    do_start(from_done);
    conv_phase(conv1_pix);
    fc_phase(stress, logit, old_res);
    chk("trigger_count", n_trig - trig0, 3);
    chk("save_done_count", n_save - save0, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_conv_clear", conv_clear, 1);
    chk("rst_pulses", {conv_trigger, conv_save_done, psum_clear, fcn_start, fc1_next, wmem_rd, wload_req}, 0);
    chk("rst_result", result, 0);
    rst = 1'b0;
    step();

    // Nominal run with extra pixels, fc1_valid during FC_NEXT and start during FC_WAIT
    full_run(6, 1'b1, 1'b0, 24'hFFFFFB, 24'h0);

    // Abort beats start in DONE
    start = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_start_done", done, 0);
    chk("abort_start_trigger", conv_trigger, 0);
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);
    chk("abort_idle_conv_clear", conv_clear, 1);
    chk("abort_keeps_result", result, 24'hFFFFFB);

    // Watchdog on a withheld wload_ack
    do_start(1'b0);
    exp_psum.push_back(1'b1);
    pixels(CONV_PIX);
    repeat (TIMEOUT - 1) step();
    chk("wdog_not_yet", err, 0);
    chk("wdog_req_held", wload_req, 1);
    step();
    chk("wdog_err", err, 1);
    chk("wdog_busy", busy, 0);
    chk("wdog_req_dropped", wload_req, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_ignores_start", err, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_clears_err", err, 0);
    chk("abort_from_err_clear", conv_clear, 1);

    // Asynchronous reset in FC_LOAD
    do_start(1'b0);
    conv_phase(CONV_PIX);
    begin
      int i;
      i = 0;
      while (!wmem_rd && i < 20) begin
        step();
        i++;
      end
      chk("wmem_rd_seen", wmem_rd, 1);
    end
    step();
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_conv_clear", conv_clear, 1);
    chk("arst_result", result, 0);
    chk("arst_w_stream", w_stream, 0);
    step();
    rst = 1'b0;
    exp_trig.delete();
    exp_psum.delete();
    exp_ch.delete();
    exp_w.delete();
    exp_res.delete();
    step();

    // Clean run after reset, then done holds, then restart from DONE
    full_run(CONV_PIX, 1'b0, 1'b0, 24'd100, 24'h0);
    repeat (3) step();
    chk("done_holds", done, 1);
    chk("w_stream_holds", w_stream, 32'h0C0B0A09);
    full_run(CONV_PIX, 1'b0, 1'b1, 24'hFFFFFB, 24'd100);

    step();
    chk("left_trig", exp_trig.size(), 0);
    chk("left_psum", exp_psum.size(), 0);
    chk("left_ch", exp_ch.size(), 0);
    chk("left_w", exp_w.size(), 0);
    chk("left_res", exp_res.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
